pll_rst_seq: RTL and testbench

- Reset sequencer directly downstream of the system PLL wrapper.
- Runs on the free-running 50 MHz reference clock, never on a PLL output, so it keeps running while the PLL is down.
- Takes the PLL's asynchronous locked output, synchronizes it, qualifies it for stability and then releases per-domain resets in a fixed staged order.
- On lock timeout it pulses the PLL reset and retries; on lock loss during operation it re-asserts every stage reset.

---
 rtl/pll_rst_seq.sv | 150 +++++++++++++++
 tb/tb_pll_rst_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the system PLL. It runs on the free-running reference clock,
// qualifies the PLL lock and releases the downstream domain resets one stage at a time.
module pll_rst_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_CYC   = 1024,
  parameter int STAGE_GAP    = 16,
  parameter int NSTAGE       = 4,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int PLLRST_CYC   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pll_locked,
  input  logic              soft_rst,
  output logic              pll_rst,
  output logic [NSTAGE-1:0] stage_rstn,
  output logic              ready,
  output logic [7:0]        retry_cnt,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // The shared counter must also hold the pulse and gap terminal counts.
  localparam int CMAX_A = (LOCK_TIMEOUT > STABLE_CYC) ? LOCK_TIMEOUT : STABLE_CYC;
  localparam int CMAX_B = (PLLRST_CYC > STAGE_GAP) ? PLLRST_CYC : STAGE_GAP;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int IW     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLLRST_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NSTAGE - 1);

  state_t                 st;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lk    = sync_q[SYNC_STAGES-1];
  assign state = st;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= S_PLL_RST;
      cnt        <= '0;
      idx        <= '0;
      pll_rst    <= 1'b1;
      stage_rstn <= '0;
      ready      <= 1'b0;
      retry_cnt  <= 8'd0;
    end else begin
      case (st)
        S_PLL_RST: begin
          pll_rst    <= 1'b1;
          stage_rstn <= '0;
          ready      <= 1'b0;
          if (cnt == PLLRST_LAST) begin
            st      <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_WAIT_LOCK: begin
          pll_rst <= 1'b0;
          if (lk) begin
            st  <= S_STABLE;
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            st      <= S_PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != 8'hff) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STABLE: begin
          if (!lk) begin
            st  <= S_WAIT_LOCK;
            cnt <= '0;
          end else if (soft_rst) begin
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            st  <= S_RELEASE;
            cnt <= '0;
            idx <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RELEASE: begin
          if (!lk || soft_rst) begin
            // Lock loss outranks a soft request: it must go back to waiting for lock.
            st         <= lk ? S_STABLE : S_WAIT_LOCK;
            cnt        <= '0;
            stage_rstn <= '0;
            ready      <= 1'b0;
          end else if (cnt == GAP_LAST) begin
            stage_rstn[idx] <= 1'b1;
            idx             <= idx + IW'(1);
            cnt             <= '0;
            if (idx == IDX_LAST) st <= S_RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RUN: begin
          if (!lk || soft_rst) begin
            st         <= lk ? S_STABLE : S_WAIT_LOCK;
            cnt        <= '0;
            stage_rstn <= '0;
            ready      <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end

        default: begin
          st         <= S_PLL_RST;
          cnt        <= '0;
          pll_rst    <= 1'b1;
          stage_rstn <= '0;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: bring-up, timeout retries, unstable lock, lock loss,
// soft reset mid-release and asynchronous reset, checked against a queue of expected values.
module tb_pll_rst_seq;

  localparam int SYNC_STAGES  = 2;
  localparam int STABLE_CYC   = 8;
  localparam int STAGE_GAP    = 4;
  localparam int NSTAGE       = 4;
  localparam int LOCK_TIMEOUT = 50;
  localparam int PLLRST_CYC   = 5;
  localparam int BOUND        = 400;

  logic              clk;
  logic              rstn;
  logic              pll_locked;
  logic              soft_rst;
  logic              pll_rst;
  logic [NSTAGE-1:0] stage_rstn;
  logic              ready;
  logic [7:0]        retry_cnt;
  logic [2:0]        state;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_errors;
  logic        mon_en;
  logic        pll_seen;

  pll_rst_seq #(
    .SYNC_STAGES (SYNC_STAGES),
    .STABLE_CYC  (STABLE_CYC),
    .STAGE_GAP   (STAGE_GAP),
    .NSTAGE      (NSTAGE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .PLLRST_CYC  (PLLRST_CYC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pll_locked(pll_locked),
    .soft_rst  (soft_rst),
    .pll_rst   (pll_rst),
    .stage_rstn(stage_rstn),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && pll_rst === 1'b1) pll_seen = 1'b1;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, output int n);
    n = 0;
    while (state !== s && n < BOUND) begin tick(); n++; end
    if (state !== s) n = -1;
  endtask

  task automatic wait_stage(input logic [NSTAGE-1:0] v, output int n);
    n = 0;
    while (stage_rstn !== v && n < BOUND) begin tick(); n++; end
    if (stage_rstn !== v) n = -1;
  endtask

  task automatic wait_stage_change(output int n);
    logic [NSTAGE-1:0] prev;
    prev = stage_rstn;
    n = 0;
    while (stage_rstn === prev && n < BOUND) begin tick(); n++; end
    if (stage_rstn === prev) n = -1;
  endtask

  task automatic wait_pll(input logic v, output int n);
    n = 0;
    while (pll_rst !== v && n < BOUND) begin tick(); n++; end
    if (pll_rst !== v) n = -1;
  endtask

  // scoreboard
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed=%0h, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    int n;
    int w;
    logic bad_state;
    logic bad_out;
    logic seen_stable;
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    pll_seen = 1'b0;
    rstn       = 1'b0;
    pll_locked = 1'b0;
    soft_rst   = 1'b0;

    // Reset state
    tick(); tick();
    push(32'd0); chk("rst_state", {29'd0, state});
    push(32'd1); chk("rst_pll_rst", {31'd0, pll_rst});
    push(32'd0); chk("rst_stage", {28'd0, stage_rstn});
    push(32'd0); chk("rst_ready", {31'd0, ready});
    push(32'd0); chk("rst_retry", {24'd0, retry_cnt});

    // Normal bring-up
    rstn = 1'b1;
    push(PLLRST_CYC); wait_pll(1'b0, n); chk("bringup_pll_rst_width", n);
    repeat (10 - PLLRST_CYC) tick();
    pll_locked = 1'b1;
    push(SYNC_STAGES + 1); wait_state(3'd2, n); chk("bringup_lock_latency", n);
    push(STABLE_CYC + STAGE_GAP); wait_stage_change(n); chk("bringup_first_gap", n);
    push(32'h1); chk("bringup_stage0", {28'd0, stage_rstn});
    push(STAGE_GAP); wait_stage_change(n); chk("bringup_gap1", n);
    push(32'h3); chk("bringup_stage1", {28'd0, stage_rstn});
    push(STAGE_GAP); wait_stage_change(n); chk("bringup_gap2", n);
    push(32'h7); chk("bringup_stage2", {28'd0, stage_rstn});
    push(STAGE_GAP); wait_stage_change(n); chk("bringup_gap3", n);
    push(32'hf); chk("bringup_stage3", {28'd0, stage_rstn});
    push(32'd0); chk("bringup_ready_early", {31'd0, ready});
    tick();
    push(32'd1); chk("bringup_ready", {31'd0, ready});
    push(32'd4); chk("bringup_state_run", {29'd0, state});
    push(32'd0); chk("bringup_retry", {24'd0, retry_cnt});

    // Lock loss in RUN: one-cycle dropout
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    push(32'hf); chk("loss_stage_held", {28'd0, stage_rstn});
    tick();
    push(32'h0); chk("loss_stage_cleared", {28'd0, stage_rstn});
    push(32'd0); chk("loss_ready", {31'd0, ready});
    push(32'd1); chk("loss_state", {29'd0, state});
    push(1 + STABLE_CYC + NSTAGE * STAGE_GAP); wait_stage(4'hf, n); chk("loss_rerelease", n);

    // soft_rst in RUN, then during RELEASE at 0011
    mon_en = 1'b1;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    push(32'h0); chk("soft_run_stage", {28'd0, stage_rstn});
    push(32'd2); chk("soft_run_state", {29'd0, state});
    wait_stage(4'h3, n);
    push(32'd1); chk("soft_reach_0011", {31'd0, (n >= 0)});
    soft_rst = 1'b1;
    tick();
    push(32'h0); chk("soft_rel_stage", {28'd0, stage_rstn});
    repeat (4) tick();
    push(32'd2); chk("soft_hold_state", {29'd0, state});
    soft_rst = 1'b0;
    push(STABLE_CYC); wait_state(3'd3, n); chk("soft_requalify", n);
    push(32'd0); chk("soft_no_pll_rst", {31'd0, pll_seen});
    mon_en = 1'b0;

    // Timeout retry with lock held low
    pll_locked = 1'b0;
    push(SYNC_STAGES + 1 + LOCK_TIMEOUT); wait_pll(1'b1, n); chk("to_first_retry", n);
    push(32'd1); chk("to_retry1", {24'd0, retry_cnt});
    for (int k = 2; k <= 3; k++) begin
      push(PLLRST_CYC); wait_pll(1'b0, w); chk("to_pulse_width", w);
      push(PLLRST_CYC + LOCK_TIMEOUT); wait_pll(1'b1, n); chk("to_period", w + n);
      push(k); chk("to_retry_k", {24'd0, retry_cnt});
      push(32'h0); chk("to_stage", {28'd0, stage_rstn});
    end

    // Unstable lock: 5 high, 1 low, repeated
    wait_state(3'd1, n);
    bad_state   = 1'b0;
    bad_out     = 1'b0;
    seen_stable = 1'b0;
    for (int r = 0; r < 10; r++) begin
      pll_locked = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c == 5) pll_locked = 1'b0;
        tick();
        if (state !== 3'd1 && state !== 3'd2) bad_state = 1'b1;
        if (stage_rstn !== 4'h0 || ready !== 1'b0) bad_out = 1'b1;
        if (state === 3'd2) seen_stable = 1'b1;
      end
    end
    push(32'd0); chk("unstable_state", {31'd0, bad_state});
    push(32'd0); chk("unstable_outputs", {31'd0, bad_out});
    push(32'd1); chk("unstable_saw_stable", {31'd0, seen_stable});
    push(32'd3); chk("unstable_retry", {24'd0, retry_cnt});

    // Async reset mid-RELEASE
    pll_locked = 1'b1;
    wait_stage(4'h1, n);
    push(32'd1); chk("async_reach_release", {31'd0, (n >= 0)});
    #3 rstn = 1'b0;
    #1;
    push(32'd1); chk("async_pll_rst", {31'd0, pll_rst});
    push(32'h0); chk("async_stage", {28'd0, stage_rstn});
    push(32'd0); chk("async_retry", {24'd0, retry_cnt});
    push(32'd0); chk("async_state", {29'd0, state});
    push(32'd0); chk("async_ready", {31'd0, ready});
    tick();
    rstn = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < BOUND) begin tick(); n++; end
    push(32'd1); chk("async_rebringup_ready", {31'd0, ready});
    push(32'hf); chk("async_rebringup_stage", {28'd0, stage_rstn});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
